// File: rtl/seq_div.sv
// seq_div: radix-2 restoring divider retiring one quotient bit per cycle behind ready/valid handshakes
module seq_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH:0] shifted;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic dbz_q, dbz_d, ge;
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        ge = shifted >= {1'b0, dsr_q};
        state_d = state_q;
        rem_d = rem_q;
        quo_d = quo_q;
        dsr_d = dsr_q;
        cnt_d = cnt_q;
        dbz_d = dbz_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = RUN;
                dsr_d = divisor;
                quo_d = dividend;
                rem_d = '0;
                cnt_d = CW'(WIDTH - 1);
                dbz_d = divisor == '0;
            end
            RUN: begin
                rem_d = ge ? WIDTH'(shifted - {1'b0, dsr_q}) : shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ge};
                state_d = cnt_q == '0 ? DONE : RUN;
                cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            dsr_q <= dsr_d;
            cnt_q <= cnt_d;
            dbz_q <= dbz_d;
        end
    end
    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign quotient = quo_q;
    assign remainder = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: randomized scoreboard bench for seq_div against an arithmetic reference model
module tb_seq_div;
    localparam int W = 8;
    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           acc;
    } exp_t;
    logic clk, rst, in_valid, in_ready, out_valid, out_ready, div_by_zero;
    logic [W-1:0] dividend, divisor, quotient, remainder;
    exp_t sb[$];
    int checks = 0, failures = 0, cyc = 0, mode = 0;
    seq_div #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", n, act, exp);
        end
    endtask
    task automatic timeout(input string n);
        checks++;
        failures++;
        $display("FAIL %s got=timeout expected=handshake", n);
    endtask
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
        exp_t e;
        e.z = b == 0;
        e.q = e.z ? {W{1'b1}} : a / b;
        e.r = e.z ? a : a % b;
        e.acc = acc;
        return e;
    endfunction
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int t = 0;
        in_valid = 1;
        dividend = a;
        divisor = b;
        while (in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) timeout("accept");
        else sb.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        in_valid = 0;
    endtask
    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) timeout("drain");
    endtask
    initial begin
        int hv = 0;
        out_ready = 0;
        forever begin
            @(posedge clk);
            #2;
            hv = out_valid === 1'b1 ? hv + 1 : 0;
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : hv >= 7;
        end
    end
    initial begin
        bit prev = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    timeout("unexpected_result");
                end else begin
                    e = sb[0];
                    if (!prev) chk("latency", cyc - e.acc, W);
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", div_by_zero, e.z);
                    chk("in_ready_busy", in_ready, 0);
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev = out_valid === 1'b1;
        end
    end
    initial begin
        logic [W-1:0] a, b;
        rst = 1;
        in_valid = 0;
        dividend = 0;
        divisor = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst = 0;
        issue(200, 7);
        issue(255, 1);
        issue(5, 9);
        issue(0, 3);
        issue(255, 255);
        issue(173, 0);
        issue(10, 2);
        drain();
        mode = 2;
        issue(123, 11);
        drain();
        mode = 0;
        issue(50, 6);
        repeat (2) begin
            @(negedge clk);
            in_valid = 1;
            dividend = 3;
            divisor = 1;
        end
        @(negedge clk);
        in_valid = 0;
        drain();
        issue(77, 3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        sb.delete();
        chk("midrun_in_ready", in_ready, 1);
        chk("midrun_out_valid", out_valid, 0);
        chk("midrun_quotient", quotient, 0);
        chk("midrun_remainder", remainder, 0);
        chk("midrun_dbz", div_by_zero, 0);
        issue(100, 10);
        drain();
        mode = 1;
        for (int i = 0; i < 2000; i++) begin
            a = W'($urandom);
            b = $urandom_range(0, 9) == 0 ? '0 : W'($urandom_range(1, (1 << W) - 1));
            issue(a, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
